// File: rtl/shb_pkg.sv
// Shared constants for the shrinked 8-bit AHB slave fabric: response codes,
// fabric FSM state encoding, data-phase select width and default-slave code.
package shb_pkg;

  localparam logic HRESP_OKAY  = 1'b1;
  localparam logic HRESP_ERROR = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } shb_state_e;

  // Up to 8 slaves plus the built-in default slave need 4 bits of select.
  localparam int SEL_W = 4;
  localparam logic [SEL_W-1:0] SEL_DEF = 4'd8;

  function automatic int cnt_width(input int tmo);
    if (tmo < 1) begin
      return 1;
    end else begin
      return $clog2(tmo + 1);
    end
  endfunction

endpackage

// File: rtl/shb_addr_dec.sv
// Base/mask address decoder: one-hot hit vector, index and miss flag.
// Overlapping windows resolve to the lowest slave index.
module shb_addr_dec
  import shb_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int NSLV   = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] haddr,
  output logic [NSLV-1:0]   hit_onehot,
  output logic [SEL_W-1:0]  hit_idx,
  output logic              miss
);

  // Scan from the top so a lower hitting index overwrites a higher one.
  always_comb begin
    miss    = 1'b1;
    hit_idx = SEL_DEF;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (((haddr ^ SLV_BASE[i*ADDR_W +: ADDR_W]) & SLV_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
        miss    = 1'b0;
        hit_idx = SEL_W'(i);
      end else begin
        miss    = miss;
        hit_idx = hit_idx;
      end
    end
    hit_onehot = miss ? '0 : (NSLV'(1) << hit_idx);
  end

endmodule

// File: rtl/shb_slave_fabric.sv
// SHB slave fabric: decode, data-phase response mux, default ERROR slave and
// wait-state timeout. Define SHB_ERRLOG_EN to build the first-error address log.
module shb_slave_fabric
  import shb_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int NSLV   = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter logic [NSLV-1:0]        SLV_ZW   = '0,
  parameter int TIMEOUT = 255
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic [ADDR_W-1:0]      haddr,
  input  logic                   htrans,
  input  logic                   hwrite,
  output logic                   hready,
  output logic                   hresp,
  output logic [DATA_W-1:0]      hrdata,
  output logic [NSLV-1:0]        hsel_s,
  input  logic [NSLV-1:0]        hready_s,
  input  logic [NSLV-1:0]        hresp_s,
  input  logic [NSLV*DATA_W-1:0] hrdata_s,
  output logic                   tmo_pulse,
  output logic                   err_valid,
  output logic [ADDR_W-1:0]      err_addr,
  input  logic                   err_clr
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT);
  localparam bit TMO_EN = (TIMEOUT != 0);

  shb_state_e        state_r, state_nxt_s;
  logic [SEL_W-1:0]  data_sel_r, dec_idx_s;
  logic [NSLV-1:0]   dec_onehot_s;
  logic              dec_miss_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic              tmo_pulse_r, tmo_nxt_s;
  logic              sel_ready_s, sel_resp_s;
  logic [DATA_W-1:0] sel_rdata_s;
  logic              ready_out_s, resp_out_s;
  logic [DATA_W-1:0] rdata_out_s;
  logic              accept_s;
  logic              unused_s;

  shb_addr_dec #(
    .ADDR_W   (ADDR_W),
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .haddr      (haddr),
    .hit_onehot (dec_onehot_s),
    .hit_idx    (dec_idx_s),
    .miss       (dec_miss_s)
  );

  // Response of the slave owning the current data phase; zero-wait slaves are always ready.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_resp_s  = HRESP_ERROR;
    sel_rdata_s = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (data_sel_r == SEL_W'(i)) begin
        sel_ready_s = SLV_ZW[i] | hready_s[i];
        sel_resp_s  = hresp_s[i];
        sel_rdata_s = hrdata_s[i*DATA_W +: DATA_W];
      end else begin
        sel_ready_s = sel_ready_s;
        sel_resp_s  = sel_resp_s;
        sel_rdata_s = sel_rdata_s;
      end
    end
  end

  // Master-facing response by state; the default slave drives a two-cycle ERROR.
  always_comb begin
    ready_out_s = 1'b1;
    resp_out_s  = HRESP_OKAY;
    rdata_out_s = '0;
    case (state_r)
      ST_IDLE: begin
        ready_out_s = 1'b1;
        resp_out_s  = HRESP_OKAY;
      end
      ST_DATA: begin
        ready_out_s = sel_ready_s;
        resp_out_s  = sel_resp_s;
        rdata_out_s = sel_rdata_s;
      end
      ST_ERR1: begin
        ready_out_s = 1'b0;
        resp_out_s  = HRESP_ERROR;
      end
      ST_ERR2: begin
        ready_out_s = 1'b1;
        resp_out_s  = HRESP_ERROR;
      end
      default: begin
        ready_out_s = 1'b1;
        resp_out_s  = HRESP_OKAY;
      end
    endcase
  end

  // The ERROR completion cycle never accepts a new address phase.
  assign accept_s  = htrans & ready_out_s & (state_r != ST_ERR2);
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);

  // Next state, wait counter and timeout detection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    tmo_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (accept_s) begin
          state_nxt_s = dec_miss_s ? ST_ERR1 : ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (sel_ready_s) begin
          cnt_nxt_s = '0;
          if (accept_s) begin
            state_nxt_s = dec_miss_s ? ST_ERR1 : ST_DATA;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (TMO_EN && (cnt_inc_s == TMO_VAL)) begin
          state_nxt_s = ST_ERR1;
          cnt_nxt_s   = '0;
          tmo_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = cnt_inc_s;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      ST_ERR2: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM, data-phase select, wait counter and timeout pulse registers.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_r     <= ST_IDLE;
      data_sel_r  <= SEL_DEF;
      cnt_r       <= '0;
      tmo_pulse_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tmo_pulse_r <= tmo_nxt_s;
      if (accept_s) begin
        data_sel_r <= dec_idx_s;
      end else begin
        data_sel_r <= data_sel_r;
      end
    end
  end

  assign hready    = ready_out_s;
  assign hresp     = resp_out_s;
  assign hrdata    = rdata_out_s;
  assign tmo_pulse = tmo_pulse_r;
  assign hsel_s    = (htrans && (state_r != ST_ERR2)) ? dec_onehot_s : '0;

`ifdef SHB_ERRLOG_EN
  logic              err_valid_r;
  logic [ADDR_W-1:0] err_addr_r, addr_q_r, err_src_s;
  logic              err_entry_s;

  assign err_entry_s = (state_nxt_s == ST_ERR1) && (state_r != ST_ERR1);
  // A miss is logged on its accept edge, so its address is still on haddr.
  assign err_src_s   = accept_s ? haddr : addr_q_r;

  // First-error address log; a new error outranks a coincident clear.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      addr_q_r    <= '0;
      err_valid_r <= 1'b0;
      err_addr_r  <= '0;
    end else begin
      if (accept_s) begin
        addr_q_r <= haddr;
      end else begin
        addr_q_r <= addr_q_r;
      end
      if (err_entry_s && (!err_valid_r || err_clr)) begin
        err_valid_r <= 1'b1;
        err_addr_r  <= err_src_s;
      end else if (err_clr) begin
        err_valid_r <= 1'b0;
      end else begin
        err_valid_r <= err_valid_r;
      end
    end
  end

  assign err_valid = err_valid_r;
  assign err_addr  = err_addr_r;
  assign unused_s  = hwrite;
`else
  assign err_valid = 1'b0;
  assign err_addr  = '0;
  assign unused_s  = hwrite ^ err_clr;
`endif

endmodule

// File: tb/tb_shb_slave_fabric.sv
// Bench for shb_slave_fabric: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level model of the fabric.
module tb_shb_slave_fabric;

  localparam int NS  = 3;
  localparam int TMO = 4;
  localparam logic [23:0] RD = 24'h332211;
`ifdef SHB_ERRLOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [23:0] haddr;
  logic        htrans, hwrite, err_clr;
  logic        hready, hresp, tmo_pulse, err_valid;
  logic [7:0]  hrdata;
  logic [2:0]  hsel_s, hready_s, hresp_s;
  logic [23:0] hrdata_s, err_addr;

  always #5 hclk = ~hclk;

  shb_slave_fabric #(
    .ADDR_W   (24),
    .DATA_W   (8),
    .NSLV     (NS),
    .SLV_BASE ({24'hC00000, 24'hA00000, 24'hC00500}),
    .SLV_MASK ({24'hFF0000, 24'hFF0000, 24'hFFFF00}),
    .SLV_ZW   (3'b010),
    .TIMEOUT  (TMO)
  ) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hready    (hready),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .hsel_s    (hsel_s),
    .hready_s  (hready_s),
    .hresp_s   (hresp_s),
    .hrdata_s  (hrdata_s),
    .tmo_pulse (tmo_pulse),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  // Address map as the bench sees it.
  logic [23:0] m_base [NS] = '{24'hC00500, 24'hA00000, 24'hC00000};
  logic [23:0] m_mask [NS] = '{24'hFFFF00, 24'hFF0000, 24'hFF0000};
  bit          m_zw   [NS] = '{1'b0, 1'b1, 1'b0};

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Transaction-level model: who owns the data phase, error cycles left, waits so far.
  int          dp, errc, waits;
  logic [23:0] dp_addr, ea;
  bit          tmo_e, ev;

  function automatic int lowest_hit(input logic [23:0] a);
    for (int i = 0; i < NS; i++) begin
      if (((a ^ m_base[i]) & m_mask[i]) == 24'h0) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    dp = -1; errc = 0; waits = 0; dp_addr = 24'h0;
    tmo_e = 1'b0; ev = 1'b0; ea = 24'h0;
  endtask

  // One bus cycle: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input bit t, input logic [23:0] a, input logic [2:0] rdy,
                       input logic [2:0] rsp, input logic [23:0] rd, input bit clr);
    bit e_rdy, e_resp, acc, tmo_n, enew;
    logic [7:0]  e_rd;
    logic [2:0]  e_sel;
    logic [23:0] eaddr;
    int k;
    @(negedge hclk);
    htrans = t; haddr = a; hready_s = rdy; hresp_s = rsp; hrdata_s = rd;
    err_clr = clr; hwrite = 1'($urandom_range(0, 1));
    #1;
    k = lowest_hit(a);
    e_rd = 8'h00;
    if (errc == 2) begin
      e_rdy = 1'b0; e_resp = 1'b0;
    end else if (errc == 1) begin
      e_rdy = 1'b1; e_resp = 1'b0;
    end else if (dp >= 0) begin
      e_rdy = m_zw[dp] | rdy[dp]; e_resp = rsp[dp]; e_rd = rd[dp*8 +: 8];
    end else begin
      e_rdy = 1'b1; e_resp = 1'b1;
    end
    e_sel = 3'b000;
    if (t && errc != 1 && k >= 0) e_sel = 3'b001 << k;
    check("hready", hready, e_rdy);
    check("hresp", hresp, e_resp);
    check("hrdata", hrdata, e_rd);
    check("hsel_s", hsel_s, e_sel);
    check("tmo_pulse", tmo_pulse, tmo_e);
    check("err_valid", err_valid, LOG_EN ? ev : 1'b0);
    check("err_addr", err_addr, LOG_EN ? ea : 24'h0);
    acc = t && e_rdy && errc != 1;
    tmo_n = 1'b0; enew = 1'b0; eaddr = 24'h0;
    if (errc == 2) errc = 1;
    else if (errc == 1) errc = 0;
    else if (dp >= 0 && !e_rdy) begin
      waits++;
      if (waits == TMO) begin
        errc = 2; dp = -1; waits = 0; tmo_n = 1'b1; enew = 1'b1; eaddr = dp_addr;
      end
    end else begin
      waits = 0; dp = -1;
      if (acc) begin
        if (k >= 0) begin dp = k; dp_addr = a; end
        else begin errc = 2; enew = 1'b1; eaddr = a; end
      end
    end
    tmo_e = tmo_n;
    if (enew && (!ev || clr)) begin ev = 1'b1; ea = eaddr; end
    else if (clr) ev = 1'b0;
  endtask

  initial begin
    logic [23:0] a;
    logic [2:0]  rdy, rsp;
    hreset_n = 1'b0; htrans = 1'b0; haddr = 24'h0; hwrite = 1'b0; err_clr = 1'b0;
    hready_s = 3'b111; hresp_s = 3'b111; hrdata_s = RD;
    model_reset();
    #3;
    check("rst_hready", hready, 1'b1);
    check("rst_hresp", hresp, 1'b1);
    check("rst_hrdata", hrdata, 8'h00);
    check("rst_tmo", tmo_pulse, 1'b0);
    check("rst_err_valid", err_valid, 1'b0);
    check("rst_err_addr", err_addr, 24'h0);
    @(negedge hclk);
    hreset_n = 1'b1;

    // Read from slave0 (overlaps slave2, lowest index wins)
    cycle(1'b1, 24'hC00510, 3'b111, 3'b111, RD, 1'b0);
    check("rd_hsel", hsel_s, 3'b001);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("rd_data", hrdata, 8'h11);
    check("rd_resp", hresp, 1'b1);
    check("rd_ready", hready, 1'b1);

    // Unmapped address -> two-cycle ERROR
    cycle(1'b1, 24'h100000, 3'b111, 3'b111, RD, 1'b0);
    check("miss_hsel", hsel_s, 3'b000);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("miss_rdy1", hready, 1'b0);
    check("miss_resp1", hresp, 1'b0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("miss_rdy2", hready, 1'b1);
    check("miss_resp2", hresp, 1'b0);
    check("log_v1", err_valid, LOG_EN);
    check("log_a1", err_addr, LOG_EN ? 24'h100000 : 24'h0);
    cycle(1'b1, 24'h200000, 3'b111, 3'b111, RD, 1'b0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("log_a2", err_addr, LOG_EN ? 24'h100000 : 24'h0);

    // Timeout: slave0 never ready
    cycle(1'b1, 24'hC00510, 3'b000, 3'b111, RD, 1'b0);
    for (int i = 0; i < TMO; i++) begin
      cycle(1'b0, 24'h0, 3'b000, 3'b111, RD, 1'b0);
      check("tmo_wait", hready, 1'b0);
      check("tmo_quiet", tmo_pulse, 1'b0);
    end
    cycle(1'b0, 24'h0, 3'b000, 3'b111, RD, 1'b0);
    check("tmo_pulse", tmo_pulse, 1'b1);
    check("tmo_err1_rdy", hready, 1'b0);
    check("tmo_err1_resp", hresp, 1'b0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("tmo_end", tmo_pulse, 1'b0);
    check("tmo_err2_rdy", hready, 1'b1);
    check("tmo_err2_resp", hresp, 1'b0);

    // Clear the log, then a new miss relatches
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b1);
    check("log_v_hold", err_valid, LOG_EN);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("log_v_clr", err_valid, 1'b0);
    cycle(1'b1, 24'h300000, 3'b111, 3'b111, RD, 1'b0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("log_a3", err_addr, LOG_EN ? 24'h300000 : 24'h0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);

    // Back-to-back on zero-wait slave1 whose hready_s is low
    cycle(1'b1, 24'hA00010, 3'b101, 3'b111, RD, 1'b0);
    check("b2b_hsel", hsel_s, 3'b010);
    cycle(1'b1, 24'hA00011, 3'b101, 3'b111, RD, 1'b0);
    check("b2b_rdy1", hready, 1'b1);
    cycle(1'b1, 24'hA00012, 3'b101, 3'b111, RD, 1'b0);
    check("b2b_rdy2", hready, 1'b1);
    check("b2b_data", hrdata, 8'h22);
    cycle(1'b0, 24'h0, 3'b101, 3'b111, RD, 1'b0);
    check("b2b_rdy3", hready, 1'b1);

    // Address only in slave2's window
    cycle(1'b1, 24'hC00600, 3'b111, 3'b111, RD, 1'b0);
    check("ovl_hsel", hsel_s, 3'b100);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("ovl_data", hrdata, 8'h33);

    // Asynchronous reset during a wait state
    cycle(1'b1, 24'hC00510, 3'b000, 3'b111, RD, 1'b0);
    cycle(1'b0, 24'h0, 3'b000, 3'b111, RD, 1'b0);
    check("arst_pre", hready, 1'b0);
    #2;
    hreset_n = 1'b0;
    #1;
    check("arst_hready", hready, 1'b1);
    check("arst_hresp", hresp, 1'b1);
    check("arst_hrdata", hrdata, 8'h00);
    model_reset();
    htrans = 1'b0;
    @(negedge hclk);
    hreset_n = 1'b1;
    cycle(1'b1, 24'hC00510, 3'b111, 3'b111, RD, 1'b0);
    cycle(1'b0, 24'h0, 3'b111, 3'b111, RD, 1'b0);
    check("post_data", hrdata, 8'h11);
    check("post_resp", hresp, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 4))
        0: a = 24'hC00500 | 24'($urandom_range(0, 255));
        1: a = 24'hC00000 | 24'($urandom_range(0, 65535));
        2: a = 24'hA00000 | 24'($urandom_range(0, 65535));
        3: a = 24'($urandom());
        default: a = 24'hC00510;
      endcase
      for (int b = 0; b < NS; b++) begin
        rdy[b] = ($urandom_range(0, 9) < 7);
        rsp[b] = ($urandom_range(0, 9) < 8);
      end
      cycle(($urandom_range(0, 9) < 7), a, rdy, rsp, 24'($urandom()),
            ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
